uart_tx: RTL and testbench

UART transmitter for the 50 MHz SYSCLK domain, the transmit-side counterpart of the board's UART_RX receiver. It serializes 8-bit bytes into 8N1 frames: one start bit, 8 data bits LSB first, one stop bit. A one-byte holding register lets the next byte queue while the current frame is on the line, so back-to-back frames have no idle gap. It sits between the command/response logic and the UART TX pin.

---
 rtl/uart_tx.sv | 150 +++++++++++++++
 tb/tb_uart_tx.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx: 8N1 UART transmitter with a one-byte holding register.
//
// A byte offered on TX_DATA/TX_VALID is latched into the holding register
// whenever it is empty (TX_READY=1). The serializer pulls the held byte at
// the start of each frame, so the next byte can queue while the current
// frame is on the line and back-to-back frames have no idle gap.
//
// Parameters:
//   CLK_DIV    SYSCLK cycles per bit (2..8191), default 50 MHz / 115200.
// Ports:
//   SYSCLK     system clock
//   RST_B      asynchronous active-low reset
//   TX_DATA    byte to send, sampled on an accept edge
//   TX_VALID   request to send TX_DATA
//   TX_READY   holding register empty
//   TX_BUSY    a frame is on the line
//   TX_DONE    one-cycle pulse after the last stop-bit cycle
//   UART_TX_O  serial line, idles high, driven straight from a flop
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int unsigned CLK_DIV = 434
) (
    input  logic       SYSCLK,
    input  logic       RST_B,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    output logic       TX_READY,
    output logic       TX_BUSY,
    output logic       TX_DONE,
    output logic       UART_TX_O
);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    localparam logic [12:0] BaudLast = 13'(CLK_DIV - 1);

    state_e      state_q, state_d;
    logic [12:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_valid_q, hold_valid_d;
    logic        tx_q, tx_d;
    logic        done_q, done_d;
    logic        bit_end;

    assign bit_end = (baud_cnt_q == BaudLast);

    always_comb begin
        state_d      = state_q;
        baud_cnt_d   = baud_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        tx_d         = tx_q;
        done_d       = 1'b0;

        // Accept only into an empty holding register; the serializer only
        // drains it when full, so accept and drain never share an edge.
        if (TX_VALID && !hold_valid_q) begin
            hold_d       = TX_DATA;
            hold_valid_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                baud_cnt_d = '0;
                if (hold_valid_q) begin
                    shift_d      = hold_q;
                    hold_valid_d = 1'b0;
                    state_d      = StStart;
                    tx_d         = 1'b0;
                end
            end
            StStart: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    state_d    = StData;
                    tx_d       = shift_q[0];
                    bit_cnt_d  = '0;
                end else begin
                    baud_cnt_d = baud_cnt_q + 13'd1;
                end
            end
            StData: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (bit_cnt_q != 3'd7) begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end else begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 13'd1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    done_d     = 1'b1;
                    // A queued byte starts its frame on the same edge.
                    if (hold_valid_q) begin
                        shift_d      = hold_q;
                        hold_valid_d = 1'b0;
                        state_d      = StStart;
                        tx_d         = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 13'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge SYSCLK or negedge RST_B) begin
        if (!RST_B) begin
            state_q      <= StIdle;
            baud_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            tx_q         <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_cnt_q   <= baud_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            tx_q         <= tx_d;
            done_q       <= done_d;
        end
    end

    assign TX_READY  = !hold_valid_q;
    assign TX_BUSY   = (state_q != StIdle);
    assign TX_DONE   = done_q;
    assign UART_TX_O = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx: self-checking bench for uart_tx.
//
// A line monitor decodes every frame from the serial waveform alone (start
// edge time, one value per bit period, bit periods must be constant) and the
// directed sequence compares decoded bytes and timings against values
// computed from the frame format. A second instance with CLK_DIV=4 is
// checked cycle by cycle against the expected waveform.
// ---------------------------------------------------------------------------
module tb_uart_tx;

    localparam int D  = 434;
    localparam int D4 = 4;

    logic       clk;
    logic       rst_b;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       line;

    logic [7:0] tx_data4;
    logic       tx_valid4;
    logic       tx_ready4;
    logic       tx_busy4;
    logic       tx_done4;
    logic       line4;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rst_cnt = 0;

    logic [7:0] rx_byte[$];
    int         rx_start[$];
    bit         rx_clean[$];
    int         done_q[$];

    uart_tx #(.CLK_DIV(D)) dut (
        .SYSCLK   (clk),
        .RST_B    (rst_b),
        .TX_DATA  (tx_data),
        .TX_VALID (tx_valid),
        .TX_READY (tx_ready),
        .TX_BUSY  (tx_busy),
        .TX_DONE  (tx_done),
        .UART_TX_O(line)
    );

    uart_tx #(.CLK_DIV(D4)) dut4 (
        .SYSCLK   (clk),
        .RST_B    (rst_b),
        .TX_DATA  (tx_data4),
        .TX_VALID (tx_valid4),
        .TX_READY (tx_ready4),
        .TX_BUSY  (tx_busy4),
        .TX_DONE  (tx_done4),
        .UART_TX_O(line4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge rst_b) rst_cnt++;
    always @(negedge clk) if (tx_done === 1'b1) done_q.push_back(cyc);

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Frame decoder working only from the line waveform.
    always begin : mon
        int         t0;
        int         rc;
        logic [9:0] first;
        bit         clean;
        @(negedge clk);
        if (rst_b === 1'b1 && line === 1'b0) begin
            t0    = cyc;
            rc    = rst_cnt;
            first = '0;
            clean = 1'b1;
            for (int j = 0; j < 10 * D; j++) begin
                if (j > 0) @(negedge clk);
                if (j % D == 0) first[j / D] = line;
                else if (line !== first[j / D]) clean = 1'b0;
            end
            if (rst_cnt == rc) begin
                rx_byte.push_back(first[8:1]);
                rx_start.push_back(t0);
                rx_clean.push_back(clean && first[0] == 1'b0 && first[9] == 1'b1);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Called at a negedge; returns the accept edge number (or -1 on timeout).
    task automatic send(input logic [7:0] b, input bit keep, output int acc);
        tx_data  = b;
        tx_valid = 1'b1;
        acc      = -1;
        for (int i = 0; i < 20000; i++) begin
            if (tx_ready === 1'b1) begin
                @(negedge clk);
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (!keep) tx_valid = 1'b0;
        check("accept_timeout", {31'd0, acc >= 0}, 32'd1);
    endtask

    task automatic wait_rx(input int n);
        for (int i = 0; i < n * 10 * D + 2000; i++) begin
            if (rx_byte.size() >= n) break;
            @(negedge clk);
        end
        check("frame_count", rx_byte.size(), n);
        repeat (3) @(negedge clk);
    endtask

    task automatic clear_logs();
        rx_byte.delete();
        rx_start.delete();
        rx_clean.delete();
        done_q.delete();
    endtask

    initial begin : main
        int         acc;
        int         acc2;
        int         st;
        int         e;
        int         nd;
        bit         idle_ok;
        logic [7:0] exp_q[$];
        logic [7:0] b;

        rst_b     = 1'b0;
        tx_data   = '0;
        tx_valid  = 1'b0;
        tx_data4  = '0;
        tx_valid4 = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_line", line, 1);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        rst_b = 1'b1;
        repeat (3) @(negedge clk);

        // CLK_DIV=4 instance, byte 0x01: 40-cycle frame checked per cycle.
        tx_data4  = 8'h01;
        tx_valid4 = 1'b1;
        @(negedge clk);
        tx_valid4 = 1'b0;
        acc = cyc;
        e   = -1;
        for (int i = 0; i < 10; i++) begin
            if (line4 === 1'b0) begin
                e = cyc;
                break;
            end
            @(negedge clk);
        end
        check("d4_start_edge", e, acc + 1);
        for (int j = 0; j < 10 * D4; j++) begin
            int   k;
            logic ev;
            logic [9:0] frame;
            frame = {1'b1, 8'h01, 1'b0};
            k     = j / D4;
            ev    = frame[k];
            check($sformatf("d4_bit_cyc%0d", j), line4, ev);
            @(negedge clk);
        end
        check("d4_done", tx_done4, 1);
        check("d4_busy_fall", tx_busy4, 0);
        repeat (5) @(negedge clk);
        clear_logs();

        // Single byte 0x55 from idle.
        send(8'h55, 1'b0, acc);
        check("t1_line_acc", line, 1);
        check("t1_busy_acc", tx_busy, 0);
        wait_cyc(acc + 1);
        check("t1_line_fall", line, 0);
        check("t1_busy_rise", tx_busy, 1);
        check("t1_ready_back", tx_ready, 1);
        st = acc + 1;
        wait_cyc(st + 10 * D - 1);
        check("t1_done_early", tx_done, 0);
        wait_cyc(st + 10 * D);
        check("t1_done", tx_done, 1);
        check("t1_busy_fall", tx_busy, 0);
        wait_cyc(st + 10 * D + 1);
        check("t1_done_pulse", tx_done, 0);
        wait_rx(1);
        check("t1_byte", rx_byte[0], 8'h55);
        check("t1_clean", rx_clean[0], 1);
        check("t1_start", rx_start[0], st);
        check("t1_ndone", done_q.size(), 1);
        check("t1_done_cyc", done_q[0], st + 10 * D);
        clear_logs();

        // 0xA5 then 0x3C 100 cycles later: back-to-back frames.
        send(8'hA5, 1'b0, acc);
        st = acc + 1;
        wait_cyc(acc + 100);
        send(8'h3C, 1'b0, acc2);
        check("t2_ready_low", tx_ready, 0);
        wait_cyc(st + 10 * D - 1);
        check("t2_ready_still_low", tx_ready, 0);
        wait_cyc(st + 10 * D);
        check("t2_ready_back", tx_ready, 1);
        check("t2_busy_held", tx_busy, 1);
        check("t2_done1", tx_done, 1);
        check("t2_line_start2", line, 0);
        wait_rx(2);
        check("t2_byte0", rx_byte[0], 8'hA5);
        check("t2_byte1", rx_byte[1], 8'h3C);
        check("t2_clean0", rx_clean[0], 1);
        check("t2_clean1", rx_clean[1], 1);
        check("t2_start0", rx_start[0], st);
        check("t2_gap", rx_start[1] - rx_start[0], 10 * D);
        check("t2_ndone", done_q.size(), 2);
        clear_logs();

        // TX_VALID held high, 0xFF, 0x00, 0x81 offered in turn.
        send(8'hFF, 1'b1, acc);
        send(8'h00, 1'b1, acc);
        send(8'h81, 1'b1, acc);
        tx_data  = 8'hEE;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_rx(3);
        check("t3_byte0", rx_byte[0], 8'hFF);
        check("t3_byte1", rx_byte[1], 8'h00);
        check("t3_byte2", rx_byte[2], 8'h81);
        check("t3_clean", {31'd0, rx_clean[0] && rx_clean[1] && rx_clean[2]}, 1);
        check("t3_gap", rx_start[2] - rx_start[0], 20 * D);
        check("t3_ndone", done_q.size(), 3);
        repeat (D + 10) @(negedge clk);
        check("t3_no_extra", rx_byte.size(), 3);
        clear_logs();

        // Reset 2000 cycles into a frame with a byte queued.
        send(8'h00, 1'b0, acc);
        st = acc + 1;
        wait_cyc(st + 5);
        send(8'h77, 1'b0, acc2);
        wait_cyc(st + 2000);
        check("t4_line_pre", line, 0);
        nd = done_q.size();
        #2 rst_b = 1'b0;
        #1;
        check("t4_line_async", line, 1);
        check("t4_ready_async", tx_ready, 1);
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        check("t4_ready_after", tx_ready, 1);
        check("t4_busy_after", tx_busy, 0);
        idle_ok = 1'b1;
        for (int i = 0; i < 12 * D; i++) begin
            if (line !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) idle_ok = 1'b0;
            @(negedge clk);
        end
        check("t4_idle_after", idle_ok, 1);
        check("t4_no_done", done_q.size(), nd);
        check("t4_no_frame", rx_byte.size(), 0);
        clear_logs();

        // Random bytes with random gaps against a queue of expected bytes.
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 300)) @(negedge clk);
            b = 8'($urandom);
            exp_q.push_back(b);
            send(b, 1'b0, acc);
        end
        wait_rx(4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t5_byte%0d", i), rx_byte[i], exp_q[i]);
            check($sformatf("t5_clean%0d", i), rx_clean[i], 1);
        end
        check("t5_ndone", done_q.size(), 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
